// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - D/E pipeline register with M/W operand forwarding for the E-stage ALU
module id_ex_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bubble,
   input  logic        hold,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_ext_imm,
   input  logic [3:0]  id_alu_op,
   input  logic        id_alu_src_b,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_write_reg,
   input  logic [1:0]  id_tnew,
   input  logic [4:0]  m_fwd_addr,
   input  logic [31:0] m_fwd_data,
   input  logic        m_fwd_valid,
   input  logic [4:0]  w_fwd_addr,
   input  logic [31:0] w_fwd_data,
   input  logic        w_fwd_valid,
   output logic [31:0] alu_in_a,
   output logic [31:0] alu_in_b,
   output logic [3:0]  alu_op,
   output logic [31:0] ex_rt_fwd,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_pc8,
   output logic [31:0] ex_instr,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic [4:0]  ex_write_reg,
   output logic [1:0]  ex_tnew
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] rs_data_q, rs_data_d;
   logic [31:0] rt_data_q, rt_data_d;
   logic [31:0] ext_imm_q, ext_imm_d;
   logic [3:0]  alu_op_q, alu_op_d;
   logic        alu_src_b_q, alu_src_b_d;
   logic [4:0]  rs_q, rs_d;
   logic [4:0]  rt_q, rt_d;
   logic [4:0]  write_reg_q, write_reg_d;
   logic [1:0]  tnew_q, tnew_d;

   logic [31:0] rs_fwd;
   logic [31:0] rt_fwd;

   // Next-state selection: hold keeps everything, bubble inserts a nop, otherwise capture D.
   // The stored Tnew is already decremented so M sees the remaining latency directly.
   always_comb begin
      pc_d        = pc_q;
      instr_d     = instr_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      ext_imm_d   = ext_imm_q;
      alu_op_d    = alu_op_q;
      alu_src_b_d = alu_src_b_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      write_reg_d = write_reg_q;
      tnew_d      = tnew_q;
      if (hold) begin
         // keep current contents
      end else if (bubble) begin
         pc_d        = RESET_PC;
         instr_d     = 32'h0;
         rs_data_d   = 32'h0;
         rt_data_d   = 32'h0;
         ext_imm_d   = 32'h0;
         alu_op_d    = 4'h0;
         alu_src_b_d = 1'b0;
         rs_d        = 5'h0;
         rt_d        = 5'h0;
         write_reg_d = 5'h0;
         tnew_d      = 2'h0;
      end else begin
         pc_d        = id_pc;
         instr_d     = id_instr;
         rs_data_d   = id_rs_data;
         rt_data_d   = id_rt_data;
         ext_imm_d   = id_ext_imm;
         alu_op_d    = id_alu_op;
         alu_src_b_d = id_alu_src_b;
         rs_d        = id_rs;
         rt_d        = id_rt;
         write_reg_d = id_write_reg;
         tnew_d      = (id_tnew == 2'd0) ? 2'd0 : id_tnew - 2'd1;
      end
   end

   // E register bank with synchronous reset taking priority over hold and bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         instr_q     <= 32'h0;
         rs_data_q   <= 32'h0;
         rt_data_q   <= 32'h0;
         ext_imm_q   <= 32'h0;
         alu_op_q    <= 4'h0;
         alu_src_b_q <= 1'b0;
         rs_q        <= 5'h0;
         rt_q        <= 5'h0;
         write_reg_q <= 5'h0;
         tnew_q      <= 2'h0;
      end else begin
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         ext_imm_q   <= ext_imm_d;
         alu_op_q    <= alu_op_d;
         alu_src_b_q <= alu_src_b_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         write_reg_q <= write_reg_d;
         tnew_q      <= tnew_d;
      end
   end

   // Operand forwarding: M beats W, register 0 always reads the captured GRF value.
   always_comb begin
      rs_fwd = rs_data_q;
      if (m_fwd_valid && (m_fwd_addr == rs_q) && (rs_q != 5'd0)) begin
         rs_fwd = m_fwd_data;
      end else if (w_fwd_valid && (w_fwd_addr == rs_q) && (rs_q != 5'd0)) begin
         rs_fwd = w_fwd_data;
      end
      rt_fwd = rt_data_q;
      if (m_fwd_valid && (m_fwd_addr == rt_q) && (rt_q != 5'd0)) begin
         rt_fwd = m_fwd_data;
      end else if (w_fwd_valid && (w_fwd_addr == rt_q) && (rt_q != 5'd0)) begin
         rt_fwd = w_fwd_data;
      end
   end

   assign alu_in_a     = rs_fwd;
   assign ex_rt_fwd    = rt_fwd;
   assign alu_in_b     = alu_src_b_q ? ext_imm_q : rt_fwd;
   assign alu_op       = alu_op_q;
   assign ex_pc        = pc_q;
   assign ex_pc8       = pc_q + 32'd8;
   assign ex_instr     = instr_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_write_reg = write_reg_q;
   assign ex_tnew      = tnew_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, bubble, hold;
   logic [31:0] id_pc, id_instr, id_rs_data, id_rt_data, id_ext_imm;
   logic [3:0]  id_alu_op;
   logic        id_alu_src_b;
   logic [4:0]  id_rs, id_rt, id_write_reg;
   logic [1:0]  id_tnew;
   logic [4:0]  m_fwd_addr, w_fwd_addr;
   logic [31:0] m_fwd_data, w_fwd_data;
   logic        m_fwd_valid, w_fwd_valid;
   logic [31:0] alu_in_a, alu_in_b, ex_rt_fwd, ex_pc, ex_pc8, ex_instr;
   logic [3:0]  alu_op;
   logic [4:0]  ex_rs, ex_rt, ex_write_reg;
   logic [1:0]  ex_tnew;

   int total = 0;
   int bad   = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .bubble(bubble), .hold(hold),
      .id_pc(id_pc), .id_instr(id_instr), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_ext_imm(id_ext_imm), .id_alu_op(id_alu_op),
      .id_alu_src_b(id_alu_src_b), .id_rs(id_rs), .id_rt(id_rt),
      .id_write_reg(id_write_reg), .id_tnew(id_tnew),
      .m_fwd_addr(m_fwd_addr), .m_fwd_data(m_fwd_data), .m_fwd_valid(m_fwd_valid),
      .w_fwd_addr(w_fwd_addr), .w_fwd_data(w_fwd_data), .w_fwd_valid(w_fwd_valid),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op(alu_op),
      .ex_rt_fwd(ex_rt_fwd), .ex_pc(ex_pc), .ex_pc8(ex_pc8), .ex_instr(ex_instr),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg), .ex_tnew(ex_tnew)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] rs, input logic [31:0] rs_d,
                       input logic [4:0] rt, input logic [31:0] rt_d,
                       input logic [31:0] imm, input logic [3:0] op, input logic src_b,
                       input logic [4:0] wr, input logic [1:0] tn);
      id_pc = pc; id_instr = instr; id_rs = rs; id_rs_data = rs_d;
      id_rt = rt; id_rt_data = rt_d; id_ext_imm = imm; id_alu_op = op;
      id_alu_src_b = src_b; id_write_reg = wr; id_tnew = tn;
   endtask

   initial begin
      reset = 1'b1; hold = 1'b1; bubble = 1'b0;
      load(32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd3, 32'h55, 5'd4, 32'h66,
           32'h77, 4'd3, 1'b1, 5'd9, 2'd3);
      m_fwd_addr = 5'd0; m_fwd_data = 32'h0; m_fwd_valid = 1'b0;
      w_fwd_addr = 5'd0; w_fwd_data = 32'h0; w_fwd_valid = 1'b0;

      // reset wins over hold
      tick();
      reset = 1'b0; hold = 1'b0;
      check("rst_pc", ex_pc, 32'h3000);
      check("rst_pc8", ex_pc8, 32'h3008);
      check("rst_instr", ex_instr, 32'h0);
      check("rst_op", alu_op, 32'h0);
      check("rst_wr", ex_write_reg, 32'h0);
      check("rst_a", alu_in_a, 32'h0);
      check("rst_b", alu_in_b, 32'h0);
      check("rst_tnew", ex_tnew, 32'h0);

      // plain load
      load(32'h400, 32'h0085_1023, 5'd4, 32'd5, 5'd5, 32'd7, 32'h0, 4'd1, 1'b0, 5'd2, 2'd1);
      tick();
      check("ld_a", alu_in_a, 32'd5);
      check("ld_b", alu_in_b, 32'd7);
      check("ld_op", alu_op, 32'd1);
      check("ld_pc", ex_pc, 32'h400);
      check("ld_pc8", ex_pc8, 32'h408);
      check("ld_instr", ex_instr, 32'h0085_1023);
      check("ld_rs", ex_rs, 32'd4);
      check("ld_rt", ex_rt, 32'd5);
      check("ld_wr", ex_write_reg, 32'd2);
      check("ld_tnew1", ex_tnew, 32'd0);

      // forwarding priority on rs, W-only on rt
      load(32'h404, 32'h0109_5021, 5'd8, 32'h11, 5'd9, 32'h22, 32'h0, 4'd0, 1'b0, 5'd10, 2'd1);
      tick();
      m_fwd_addr = 5'd8; m_fwd_data = 32'hAAAA; m_fwd_valid = 1'b1;
      w_fwd_addr = 5'd8; w_fwd_data = 32'hBBBB; w_fwd_valid = 1'b1;
      #1 check("fwd_m_prio", alu_in_a, 32'hAAAA);
      check("fwd_rt_nomatch", ex_rt_fwd, 32'h22);
      m_fwd_valid = 1'b0;
      #1 check("fwd_w", alu_in_a, 32'hBBBB);
      w_fwd_addr = 5'd9;
      #1 check("fwd_w_rt", ex_rt_fwd, 32'hBBBB);
      check("fwd_w_b", alu_in_b, 32'hBBBB);
      check("fwd_none_a", alu_in_a, 32'h11);
      m_fwd_addr = 5'd9; m_fwd_data = 32'hCCCC; m_fwd_valid = 1'b1;
      #1 check("fwd_m_rt", ex_rt_fwd, 32'hCCCC);
      m_fwd_valid = 1'b0; w_fwd_valid = 1'b0;

      // zero-register guard
      load(32'h408, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 4'd0, 1'b0, 5'd0, 2'd0);
      tick();
      m_fwd_addr = 5'd0; m_fwd_data = 32'h1234; m_fwd_valid = 1'b1;
      w_fwd_addr = 5'd0; w_fwd_data = 32'h5678; w_fwd_valid = 1'b1;
      #1 check("zero_rt", ex_rt_fwd, 32'h0);
      check("zero_a", alu_in_a, 32'h0);
      m_fwd_valid = 1'b0; w_fwd_valid = 1'b0;

      // immediate path, lui opcode, PC wrap in pc8
      load(32'hFFFF_FFFC, 32'h3C01_FFFF, 5'd0, 32'h0, 5'd3, 32'd9, 32'h0000_FFFF, 4'd4, 1'b1, 5'd3, 2'd2);
      tick();
      check("imm_b", alu_in_b, 32'h0000_FFFF);
      check("imm_rtfwd", ex_rt_fwd, 32'd9);
      check("imm_op", alu_op, 32'd4);
      check("wrap_pc8", ex_pc8, 32'h4);
      check("tnew2", ex_tnew, 32'd1);

      // hold beats bubble; forwarding still live while held
      load(32'h500, 32'h0123_4820, 5'd9, 32'h99, 5'd3, 32'h33, 32'h0, 4'd0, 1'b0, 5'd9, 2'd3);
      tick();
      check("h_tnew3", ex_tnew, 32'd2);
      hold = 1'b1; bubble = 1'b1;
      load(32'h504, 32'hFFFF_0000, 5'd1, 32'h1, 5'd2, 32'h2, 32'h5, 4'd2, 1'b1, 5'd7, 2'd0);
      tick();
      tick();
      check("hold_instr", ex_instr, 32'h0123_4820);
      check("hold_pc", ex_pc, 32'h500);
      check("hold_a", alu_in_a, 32'h99);
      m_fwd_addr = 5'd9; m_fwd_data = 32'hF00D; m_fwd_valid = 1'b1;
      #1 check("hold_fwd_a", alu_in_a, 32'hF00D);
      m_fwd_valid = 1'b0;

      // release hold with bubble -> nop
      hold = 1'b0;
      tick();
      check("bub_instr", ex_instr, 32'h0);
      check("bub_pc", ex_pc, 32'h3000);
      check("bub_pc8", ex_pc8, 32'h3008);
      check("bub_tnew", ex_tnew, 32'h0);
      check("bub_wr", ex_write_reg, 32'h0);
      check("bub_a", alu_in_a, 32'h0);
      check("bub_b", alu_in_b, 32'h0);
      bubble = 1'b0;

      // Tnew decrement and saturation
      load(32'h600, 32'h1, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 4'd2, 1'b0, 5'd4, 2'd2);
      tick();
      check("tnew_2", ex_tnew, 32'd1);
      check("and_op", alu_op, 32'd2);
      id_tnew = 2'd0;
      tick();
      check("tnew_0", ex_tnew, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
